// File: rtl/rh_tmr_stream_fifo.sv
// rh_tmr_stream_fifo: triplicated, majority-voted valid/ready FIFO with scrubbing and SEU reporting
module rh_tmr_stream_fifo #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int CNT_W  = 8,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              clr_count,
   input  logic              inj_en,
   input  logic [1:0]        inj_lane,
   input  logic [ADDR_W-1:0] inj_idx,
   input  logic [DATA_W-1:0] inj_mask,
   output logic              seu_event,
   output logic [CNT_W-1:0]  seu_count
);
   localparam int PW = ADDR_W + 1;

   logic [2:0][DEPTH-1:0][DATA_W-1:0] mem_q, mem_d;
   logic [2:0][PW-1:0]                wp_q, wp_d, rp_q, rp_d;
   logic [ADDR_W-1:0]                 scrub_q, scrub_d, wr_idx, rd_idx;
   logic                              evt_q, evt_d;
   logic [CNT_W-1:0]                  cnt_q, cnt_d;
   logic [PW-1:0]                     wp_v, rp_v, count;
   logic [DATA_W-1:0]                 rd_v, sc_v;
   logic                              full, empty, push, pop, det;

   function automatic logic [PW-1:0] vote_p(input logic [2:0][PW-1:0] c);
      return (c[0] & c[1]) | (c[0] & c[2]) | (c[1] & c[2]);
   endfunction

   function automatic logic [DATA_W-1:0] vote_d(input logic [DATA_W-1:0] a, b, c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   function automatic logic differ_d(input logic [DATA_W-1:0] a, b, c);
      return (a != b) || (a != c);
   endfunction

   assign wp_v      = vote_p(wp_q);
   assign rp_v      = vote_p(rp_q);
   assign wr_idx    = wp_v[ADDR_W-1:0];
   assign rd_idx    = rp_v[ADDR_W-1:0];
   assign count     = wp_v - rp_v;
   assign full      = count == PW'(DEPTH);
   assign empty     = count == '0;
   assign in_ready  = !full;
   assign out_valid = !empty;
   assign push      = in_valid & in_ready;
   assign pop       = out_valid & out_ready;
   assign rd_v      = vote_d(mem_q[0][rd_idx], mem_q[1][rd_idx], mem_q[2][rd_idx]);
   assign sc_v      = vote_d(mem_q[0][scrub_q], mem_q[1][scrub_q], mem_q[2][scrub_q]);
   assign out_data  = empty ? '0 : rd_v;
   assign seu_event = evt_q;
   assign seu_count = cnt_q;

   // Per-entry storage update: push beats injection beats scrub on the same entry
   always_comb begin
      mem_d = mem_q;
      for (int i = 0; i < DEPTH; i++) begin
         if (push && wr_idx == ADDR_W'(i)) begin
            for (int l = 0; l < 3; l++) mem_d[l][i] = in_data;
         end else if (inj_en && inj_lane != 2'd3 && inj_idx == ADDR_W'(i)) begin
            for (int l = 0; l < 3; l++) mem_d[l][i] = (inj_lane == 2'(l)) ? mem_q[l][i] ^ inj_mask : mem_q[l][i];
         end else if (scrub_q == ADDR_W'(i)) begin
            for (int l = 0; l < 3; l++) mem_d[l][i] = sc_v;
         end
      end
   end

   // Pointer repair, scrub walk and SEU detection/reporting
   always_comb begin
      wp_d    = {3{wp_v + PW'(push)}};
      rp_d    = {3{rp_v + PW'(pop)}};
      scrub_d = scrub_q + ADDR_W'(1);
      det     = (wp_q[0] != wp_q[1]) || (wp_q[0] != wp_q[2]) ||
                (rp_q[0] != rp_q[1]) || (rp_q[0] != rp_q[2]) ||
                (!empty && differ_d(mem_q[0][rd_idx], mem_q[1][rd_idx], mem_q[2][rd_idx])) ||
                differ_d(mem_q[0][scrub_q], mem_q[1][scrub_q], mem_q[2][scrub_q]);
      evt_d   = det;
      cnt_d   = clr_count ? '0 : (det && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // State registers; reset discards all contents at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q   <= '0;
         wp_q    <= '0;
         rp_q    <= '0;
         scrub_q <= '0;
         evt_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         mem_q   <= mem_d;
         wp_q    <= wp_d;
         rp_q    <= rp_d;
         scrub_q <= scrub_d;
         evt_q   <= evt_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_rh_tmr_stream_fifo.sv
// tb_rh_tmr_stream_fifo: scoreboard bench for the TMR stream FIFO
module tb_rh_tmr_stream_fifo;
   localparam int DW = 8, DEPTH = 4, CW = 8, AW = 2;

   logic          clk = 1'b0, rst_n = 1'b0;
   logic          in_valid = 1'b0, out_ready = 1'b0, clr_count = 1'b0, inj_en = 1'b0;
   logic          in_ready, out_valid, seu_event;
   logic [DW-1:0] in_data = '0, inj_mask = '0, out_data;
   logic [1:0]    inj_lane = 2'd3;
   logic [AW-1:0] inj_idx = '0;
   logic [CW-1:0] seu_count;
   int            n_cmp = 0, n_err = 0;
   logic [7:0]    sb[$];
   logic [1:0]    sc_m;
   logic          pu, po;
   logic [7:0]    pd, exp_d;
   int            evs;

   rh_tmr_stream_fifo #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .clr_count(clr_count),
      .inj_en(inj_en), .inj_lane(inj_lane), .inj_idx(inj_idx), .inj_mask(inj_mask),
      .seu_event(seu_event), .seu_count(seu_count)
   );

   always #5 clk = ~clk;

   // Reference scrub position: cycles since reset, modulo DEPTH
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) sc_m <= 2'd0;
      else sc_m <= sc_m + 2'd1;
   end

   task automatic step(input logic iv, input logic [7:0] d, input logic ordy);
      in_valid = iv; in_data = d; out_ready = ordy;
      #1;
      pu = iv & in_ready; po = out_valid & ordy; pd = out_data;
      if (pu) sb.push_back(d);
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b0; inj_en = 1'b0; inj_lane = 2'd3; clr_count = 1'b0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk);
      rst_n = 1'b1;
      sb.delete();
   endtask

   task automatic test_reset();
      apply_reset();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_err++; $display("FAIL reset_out_data: got %h want 00", out_data); end
      n_cmp++; if (seu_event !== 1'b0) begin n_err++; $display("FAIL reset_seu_event: got %b want 0", seu_event); end
      n_cmp++; if (seu_count !== 8'h00) begin n_err++; $display("FAIL reset_seu_count: got %h want 00", seu_count); end
   endtask

   task automatic test_fill_drain();
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'h11 * (i + 1)), 1'b0);
         n_cmp++; if (pu !== 1'b1) begin n_err++; $display("FAIL fill_accept%0d: got %b want 1", i, pu); end
         n_cmp++; if (in_ready !== (i < 3)) begin n_err++; $display("FAIL fill_in_ready%0d: got %b want %b", i, in_ready, i < 3); end
      end
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL full_out_valid: got %b want 1", out_valid); end
      n_cmp++; if (out_data !== 8'h11) begin n_err++; $display("FAIL full_head: got %h want 11", out_data); end
      step(1'b1, 8'h55, 1'b0);
      n_cmp++; if (pu !== 1'b0) begin n_err++; $display("FAIL full_reject: accepted=%b want 0", pu); end
      for (int i = 0; i < 4; i++) begin
         step(1'b0, 8'h00, 1'b1);
         exp_d = sb.size() ? sb[0] : 8'h00;
         n_cmp++; if (po !== 1'b1 || pd !== exp_d) begin n_err++; $display("FAIL drain%0d: pop=%b data=%h want pop=1 data=%h", i, po, pd, exp_d); end
         if (sb.size()) void'(sb.pop_front());
      end
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== 8'h00) begin n_err++; $display("FAIL drained: valid=%b ready=%b data=%h want 0 1 00", out_valid, in_ready, out_data); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 8'(i), 1'b1);
         n_cmp++; if (pu !== 1'b1 || po !== (i > 0)) begin n_err++; $display("FAIL b2b_flow%0d: push=%b pop=%b want 1 %b", i, pu, po, i > 0); end
         if (po) begin
            exp_d = sb.size() ? sb[0] : 8'h00;
            n_cmp++; if (pd !== exp_d) begin n_err++; $display("FAIL b2b_data%0d: got %h want %h", i, pd, exp_d); end
            if (sb.size()) void'(sb.pop_front());
         end
      end
      n_cmp++; if (out_valid !== 1'b1 || out_data !== 8'h13) begin n_err++; $display("FAIL b2b_tail: valid=%b data=%h want 1 13", out_valid, out_data); end
      step(1'b0, 8'h00, 1'b1);
      n_cmp++; if (po !== 1'b1 || pd !== 8'h13 || out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_last: pop=%b data=%h valid=%b want 1 13 0", po, pd, out_valid); end
      if (sb.size()) void'(sb.pop_front());
   endtask

   task automatic test_inject_head();
      apply_reset();
      step(1'b1, 8'hA5, 1'b0);
      for (int k = 0; k < 8 && sc_m != 2'd3; k++) step(1'b0, 8'h00, 1'b0);
      inj_en = 1'b1; inj_lane = 2'd1; inj_idx = 2'd0; inj_mask = 8'hFF;
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if (out_data !== 8'hA5 || seu_event !== 1'b0 || seu_count !== 8'h00) begin n_err++; $display("FAIL inj_head_t0: data=%h evt=%b cnt=%h want A5 0 00", out_data, seu_event, seu_count); end
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if (out_data !== 8'hA5 || seu_event !== 1'b1 || seu_count !== 8'h01) begin n_err++; $display("FAIL inj_head_t1: data=%h evt=%b cnt=%h want A5 1 01", out_data, seu_event, seu_count); end
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if (seu_event !== 1'b0 || seu_count !== 8'h01) begin n_err++; $display("FAIL inj_head_t2: evt=%b cnt=%h want 0 01", seu_event, seu_count); end
      step(1'b0, 8'h00, 1'b1);
      exp_d = sb.size() ? sb.pop_front() : 8'h00;
      n_cmp++; if (po !== 1'b1 || pd !== exp_d) begin n_err++; $display("FAIL inj_head_pop: pop=%b data=%h want 1 %h", po, pd, exp_d); end
   endtask

   task automatic test_inject_scrub();
      apply_reset();
      step(1'b1, 8'h10, 1'b0);
      step(1'b1, 8'h3C, 1'b0);
      for (int k = 0; k < 8 && sc_m != 2'd1; k++) step(1'b0, 8'h00, 1'b0);
      inj_en = 1'b1; inj_lane = 2'd2; inj_idx = 2'd1; inj_mask = 8'h0F;
      step(1'b0, 8'h00, 1'b0);
      evs = 0;
      for (int k = 0; k < DEPTH + 2; k++) begin step(1'b0, 8'h00, 1'b0); evs += int'(seu_event); end
      n_cmp++; if (evs != 1 || seu_count !== 8'h01) begin n_err++; $display("FAIL scrub_repair: events=%0d cnt=%h want 1 01", evs, seu_count); end
      evs = 0;
      for (int k = 0; k < DEPTH; k++) begin step(1'b0, 8'h00, 1'b0); evs += int'(seu_event); end
      n_cmp++; if (evs != 0 || seu_count !== 8'h01) begin n_err++; $display("FAIL scrub_quiet: events=%0d cnt=%h want 0 01", evs, seu_count); end
      for (int k = 0; k < 2; k++) begin
         step(1'b0, 8'h00, 1'b1);
         exp_d = sb.size() ? sb.pop_front() : 8'h00;
         n_cmp++; if (po !== 1'b1 || pd !== exp_d) begin n_err++; $display("FAIL scrub_pop%0d: pop=%b data=%h want 1 %h", k, po, pd, exp_d); end
      end
   endtask

   task automatic test_count_sat();
      apply_reset();
      step(1'b1, 8'hA5, 1'b0);
      for (int k = 0; k < 10; k++) begin
         inj_en = 1'b1; inj_lane = 2'd1; inj_idx = 2'd0; inj_mask = (k == 0) ? 8'h01 : 8'h03;
         step(1'b0, 8'h00, 1'b0);
      end
      n_cmp++; if (seu_count !== 8'd9) begin n_err++; $display("FAIL cnt_run: got %0d want 9", seu_count); end
      inj_en = 1'b1; inj_lane = 2'd1; inj_idx = 2'd0; inj_mask = 8'h03; clr_count = 1'b1;
      step(1'b0, 8'h00, 1'b0);
      n_cmp++; if (seu_count !== 8'h00 || seu_event !== 1'b1) begin n_err++; $display("FAIL cnt_clr: cnt=%h evt=%b want 00 1", seu_count, seu_event); end
      for (int k = 0; k < 270; k++) begin
         inj_en = 1'b1; inj_lane = 2'd1; inj_idx = 2'd0; inj_mask = 8'h03;
         step(1'b0, 8'h00, 1'b0);
      end
      n_cmp++; if (seu_count !== 8'hFF) begin n_err++; $display("FAIL cnt_sat: got %h want FF", seu_count); end
      n_cmp++; if (out_data !== 8'hA5 || seu_event !== 1'b1) begin n_err++; $display("FAIL cnt_vote: data=%h evt=%b want A5 1", out_data, seu_event); end
      for (int k = 0; k < DEPTH + 2; k++) step(1'b0, 8'h00, 1'b0);
      n_cmp++; if (seu_event !== 1'b0 || seu_count !== 8'hFF) begin n_err++; $display("FAIL cnt_settle: evt=%b cnt=%h want 0 FF", seu_event, seu_count); end
      step(1'b0, 8'h00, 1'b1);
      exp_d = sb.size() ? sb.pop_front() : 8'h00;
      n_cmp++; if (po !== 1'b1 || pd !== exp_d) begin n_err++; $display("FAIL cnt_pop: pop=%b data=%h want 1 %h", po, pd, exp_d); end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) step(1'b1, 8'(8'h61 + k), 1'b0);
      n_cmp++; if (out_valid !== 1'b1 || seu_count !== 8'hFF) begin n_err++; $display("FAIL mid_pre: valid=%b cnt=%h want 1 FF", out_valid, seu_count); end
      in_valid = 1'b1; in_data = 8'h77; rst_n = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || seu_count !== 8'h00 || out_data !== 8'h00) begin n_err++; $display("FAIL mid_reset: valid=%b ready=%b cnt=%h data=%h want 0 1 00 00", out_valid, in_ready, seu_count, out_data); end
      sb.delete();
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0; rst_n = 1'b1;
      step(1'b1, 8'h99, 1'b0);
      step(1'b0, 8'h00, 1'b1);
      exp_d = sb.size() ? sb.pop_front() : 8'h00;
      n_cmp++; if (po !== 1'b1 || pd !== exp_d || exp_d !== 8'h99) begin n_err++; $display("FAIL mid_first: pop=%b data=%h want 1 99", po, pd); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_empty: valid=%b want 0", out_valid); end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fill_drain();
      test_back_to_back();
      test_inject_head();
      test_inject_scrub();
      test_count_sat();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
